vga_controller: RTL and testbench



---
 rtl/vga_controller.sv | 158 +++++++++++++++
 tb/tb_vga_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_controller.sv
// vga_controller
//   Display-side reader of the RGB565 framebuffer. Generates VGA timing from
//   the system clock with a pixel-enable divider, issues linear framebuffer
//   read addresses, and converts returned RGB565 words to 4-bit-per-channel
//   VGA colour. Colour and sync outputs are registered together, so they stay
//   aligned.
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset
//   enable_i       run enable; low clears the counters and blanks the outputs
//   fb_addr_o      framebuffer read address of the current pixel (held per pixel)
//   fb_rd_o        read strobe, high while the current pixel is visible
//   fb_data_i      RGB565 read data, valid RD_LATENCY_G clocks after the address
//   vga_r/g/b_o    4-bit colour outputs
//   hsync_o        horizontal sync, active low
//   vsync_o        vertical sync, active low
//   frame_start_o  one-clock pulse when the counters wrap to (0,0)
module vga_controller #(
  parameter int DIV_G        = 4,
  parameter int RD_LATENCY_G = 1,
  parameter int H_VIS_G      = 640,
  parameter int H_FP_G       = 16,
  parameter int H_SYNC_G     = 96,
  parameter int H_BP_G       = 48,
  parameter int V_VIS_G      = 480,
  parameter int V_FP_G       = 10,
  parameter int V_SYNC_G     = 2,
  parameter int V_BP_G       = 33
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  output logic [18:0] fb_addr_o,
  output logic        fb_rd_o,
  input  logic [15:0] fb_data_i,
  output logic [3:0]  vga_r_o,
  output logic [3:0]  vga_g_o,
  output logic [3:0]  vga_b_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_start_o
);

  localparam int H_TOT    = H_VIS_G + H_FP_G + H_SYNC_G + H_BP_G;
  localparam int V_TOT    = V_VIS_G + V_FP_G + V_SYNC_G + V_BP_G;
  localparam int FB_WORDS = H_VIS_G * V_VIS_G;
  localparam int DW       = (DIV_G > 1) ? $clog2(DIV_G) : 1;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV_G - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_VIS     = HW'(H_VIS_G);
  localparam logic [VW-1:0] V_VIS     = VW'(V_VIS_G);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_VIS_G + H_FP_G);
  localparam logic [HW-1:0] HS_END    = HW'(H_VIS_G + H_FP_G + H_SYNC_G - 1);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_VIS_G + V_FP_G);
  localparam logic [VW-1:0] VS_END    = VW'(V_VIS_G + V_FP_G + V_SYNC_G - 1);
  localparam logic [18:0]   ADDR_LAST = 19'(FB_WORDS - 1);

  // Read data must land within the pixel period that presented the address.
  if (RD_LATENCY_G < 1 || RD_LATENCY_G > 2 || DIV_G < RD_LATENCY_G + 1) begin : g_param_chk
    $error("vga_controller: need RD_LATENCY_G in 1..2 and DIV_G >= RD_LATENCY_G + 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [18:0]   addr_q, addr_d;
  logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hs_q, hs_d, vs_q, vs_d;

  logic pix_en, h_last, v_last, visible, hs_raw, vs_raw;

  // enable_i gates pix_en so a disable in the last divider clock wins.
  assign pix_en  = enable_i && (div_q == DIV_LAST);
  assign h_last  = (h_q == H_LAST);
  assign v_last  = (v_q == V_LAST);
  assign visible = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_raw  = !((h_q >= HS_BEG) && (h_q <= HS_END));
  assign vs_raw  = !((v_q >= VS_BEG) && (v_q <= VS_END));

  always_comb begin
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (!enable_i) begin
      div_d  = '0;
      h_d    = '0;
      v_d    = '0;
      addr_d = '0;
      r_d    = '0;
      g_d    = '0;
      b_d    = '0;
      hs_d   = 1'b1;
      vs_d   = 1'b1;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (pix_en) begin
        h_d = h_last ? '0 : h_q + 1'b1;
        if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
        if (visible) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
        // Pixel just ending: its data is valid in this, its last, clock.
        r_d  = visible ? fb_data_i[15:12] : 4'd0;
        g_d  = visible ? fb_data_i[10:7]  : 4'd0;
        b_d  = visible ? fb_data_i[4:1]   : 4'd0;
        hs_d = hs_raw;
        vs_d = vs_raw;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  // Low-order bits dropped by RGB565 -> RGB444 truncation.
  logic unused_bits;
  assign unused_bits = ^{fb_data_i[11], fb_data_i[6:5], fb_data_i[0]};

  assign fb_addr_o     = addr_q;
  assign fb_rd_o       = rst_n_i && enable_i && visible;
  assign frame_start_o = rst_n_i && pix_en && h_last && v_last;
  assign vga_r_o       = r_q;
  assign vga_g_o       = g_q;
  assign vga_b_o       = b_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller using a reduced screen geometry so whole frames
// fit in a short run. Two instances: DIV 4 / latency 1 and DIV 3 / latency 2.
// The reference predicts every output from the count of enabled clocks alone.
module tb_vga_controller;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam logic [34:0] IDLE = {19'd0, 2'b00, 12'd0, 2'b11};

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] addr_a, addr_b;
  logic rd_a, rd_b, fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [15:0] a_d1, b_d1, b_d2;

  bit          const_mode = 1'b0;
  logic [15:0] key = 16'h0000;
  int tests = 0, fails = 0, kk = 0;
  bit meas = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
  int last_fs = -1, last_hf = -1, last_vf = -1;

  vga_controller #(.DIV_G(4), .RD_LATENCY_G(1),
    .H_VIS_G(HV), .H_FP_G(HF), .H_SYNC_G(HS), .H_BP_G(HB),
    .V_VIS_G(VV), .V_FP_G(VF), .V_SYNC_G(VS), .V_BP_G(VB)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .fb_addr_o(addr_a), .fb_rd_o(rd_a),
    .fb_data_i(a_d1), .vga_r_o(r_a), .vga_g_o(g_a), .vga_b_o(b_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .frame_start_o(fs_a));

  vga_controller #(.DIV_G(3), .RD_LATENCY_G(2),
    .H_VIS_G(HV), .H_FP_G(HF), .H_SYNC_G(HS), .H_BP_G(HB),
    .V_VIS_G(VV), .V_FP_G(VF), .V_SYNC_G(VS), .V_BP_G(VB)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .fb_addr_o(addr_b), .fb_rd_o(rd_b),
    .fb_data_i(b_d2), .vga_r_o(r_b), .vga_g_o(g_b), .vga_b_o(b_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .frame_start_o(fs_b));

  // Framebuffer contents as a function of address.
  function automatic logic [15:0] fword(input logic [18:0] a);
    return const_mode ? 16'hF81F : (a[15:0] ^ key);
  endfunction

  // Framebuffer read pipelines (latency 1 and 2).
  always @(posedge clk) begin
    a_d1 <= fword(addr_a);
    b_d1 <= fword(addr_b);
    b_d2 <= b_d1;
  end

  // Address of pixel number p since the frame origin: visible pixels before it.
  function automatic logic [18:0] addr_of(input int p);
    int h, v, n;
    h = p % HT;
    v = (p / HT) % VT;
    n = (v < VV) ? v * HV + ((h < HV) ? h : HV) : VV * HV;
    return 19'(n % (HV * VV));
  endfunction

  // Expected {addr, rd, frame_start, rgb, hs, vs} during enabled clock k.
  function automatic logic [34:0] expect_at(input int k, input int dv);
    int p, h, v, q, hq, vq;
    logic [15:0] w;
    logic [11:0] col;
    logic rd, fs, hs, vs;
    p  = k / dv;
    h  = p % HT;
    v  = (p / HT) % VT;
    rd = (h < HV) && (v < VV);
    fs = (k % dv == dv - 1) && (h == HT - 1) && (v == VT - 1);
    col = 12'd0; hs = 1'b1; vs = 1'b1;
    if (k >= dv) begin
      q  = p - 1;
      hq = q % HT;
      vq = (q / HT) % VT;
      w  = fword(addr_of(q));
      if (hq < HV && vq < VV) col = {w[15:12], w[10:7], w[4:1]};
      hs = !(hq >= HV + HF && hq < HV + HF + HS);
      vs = !(vq >= VV + VF && vq < VV + VF + VS);
    end
    return {addr_of(p), rd, fs, col, hs, vs};
  endfunction

  // mode 0: running, 1: first disabled clock, 2: idle (reset / disabled).
  task automatic check(input int mode);
    logic [34:0] oa, ob, ea, eb;
    oa = {addr_a, rd_a, fs_a, r_a, g_a, b_a, hs_a, vs_a};
    ob = {addr_b, rd_b, fs_b, r_b, g_b, b_b, hs_b, vs_b};
    ea = (mode == 2) ? IDLE : expect_at(kk, 4);
    eb = (mode == 2) ? IDLE : expect_at(kk, 3);
    if (mode == 1) begin
      ea[15:14] = 2'b00;
      eb[15:14] = 2'b00;
    end
    tests++;
    assert (oa === ea) else begin
      fails++; $error("FAIL pix_a k=%0d mode=%0d got %h want %h", kk, mode, oa, ea);
    end
    tests++;
    assert (ob === eb) else begin
      fails++; $error("FAIL pix_b k=%0d mode=%0d got %h want %h", kk, mode, ob, eb);
    end
    if (meas) begin
      if (fs_a) begin
        if (last_fs >= 0) begin
          tests++;
          assert (kk - last_fs === 4 * HT * VT) else begin
            fails++; $error("FAIL frame_period got %0d want %0d", kk - last_fs, 4 * HT * VT);
          end
        end
        last_fs = kk;
      end
      if (prev_hs && !hs_a) begin
        if (last_hf >= 0) begin
          tests++;
          assert (kk - last_hf === 4 * HT) else begin
            fails++; $error("FAIL hsync_period got %0d want %0d", kk - last_hf, 4 * HT);
          end
        end
        last_hf = kk;
      end
      if (!prev_hs && hs_a && last_hf >= 0) begin
        tests++;
        assert (kk - last_hf === 4 * HS) else begin
          fails++; $error("FAIL hsync_width got %0d want %0d", kk - last_hf, 4 * HS);
        end
      end
      if (prev_vs && !vs_a) last_vf = kk;
      if (!prev_vs && vs_a && last_vf >= 0) begin
        tests++;
        assert (kk - last_vf === 4 * VS * HT) else begin
          fails++; $error("FAIL vsync_width got %0d want %0d", kk - last_vf, 4 * VS * HT);
        end
      end
      prev_hs = hs_a;
      prev_vs = vs_a;
    end
  endtask

  task automatic run(input bit e, input int mode, input int n);
    repeat (n) begin
      @(negedge clk);
      en = e;
      #1;
      check(mode);
      if (mode == 0) kk++;
    end
  endtask

  initial begin
    // Reset held for 10 clocks, then idle with enable low.
    run(1'b0, 2, 10);
    rst_n = 1'b1;
    run(1'b0, 2, 2);

    // Address test: data = address, two full frames plus margin, with timing
    // measurements on the DIV 4 instance.
    meas = 1'b1;
    kk   = 0;
    run(1'b1, 0, 2 * 4 * HT * VT + 100);
    meas = 1'b0;

    // Enable drops at random mid-frame points, then restart with new data.
    for (int it = 0; it < 2; it++) begin
      run(1'b1, 0, $urandom_range(700, 200));
      run(1'b0, 1, 1);
      const_mode = (it == 0);
      key        = 16'($urandom);
      run(1'b0, 2, 4);
      kk = 0;
      run(1'b1, 0, 4 * HT * VT + 200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
